// File: rtl/st_pkg.sv
// Shared definitions for the store alignment buffer.
//   F3_*        : store func3 encodings (sb, sh, sw)
//   st_entry_t  : one buffered store (word address, lane-replicated data, byte enables)
//   is_legal()  : true when func3 is a store code and the address is naturally aligned
package st_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

  function automatic logic is_legal(input logic [2:0] func3, input logic [1:0] o);
    logic ok;
    case (func3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = ~o[0];
      F3_SW:   ok = (o == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/st_align.sv
// Combinational store encoder.
//   func3 : store width code
//   addr  : byte address
//   data  : rs2 value
//   entry : word address, lane-replicated write data and byte enables
//   legal : request is a store code with natural alignment
module st_align
  import st_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output st_entry_t   entry,
  output logic        legal
);

  always_comb begin
    entry.waddr = addr[31:2];
    entry.wdata = data;
    entry.be    = 4'b0000;
    legal       = is_legal(func3, addr[1:0]);
    case (func3)
      F3_SB: begin
        entry.be    = 4'b0001 << addr[1:0];
        entry.wdata = {4{data[7:0]}};
      end
      F3_SH: begin
        entry.be    = addr[1] ? 4'b1100 : 4'b0011;
        entry.wdata = {2{data[15:0]}};
      end
      F3_SW: begin
        entry.be    = 4'b1111;
        entry.wdata = data;
      end
      default: begin
        entry.be    = 4'b0000;
        entry.wdata = data;
      end
    endcase
  end

endmodule

// File: rtl/st_align_buffer.sv
// Store alignment buffer: encodes execute-stage stores and queues them toward data memory.
//   clk, rst_n              : clock, asynchronous active-low reset
//   st_valid/st_ready       : store request handshake (st_ready == !full)
//   st_func3/st_addr/st_data: store request fields
//   mem_req/mem_gnt         : head-entry issue handshake
//   mem_addr/mem_wdata/mem_be : head entry, driven from storage only
//   st_err                  : one-cycle pulse after a rejected (misaligned/illegal) request
//   empty                   : buffer holds no entries
module st_align_buffer
  import st_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_func3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_err,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  st_entry_t          in_entry;
  logic               in_legal;
  st_entry_t          buf_q [DEPTH];
  st_entry_t          head;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q, count_d;
  logic               full, accept, push, pop;
  logic               st_err_q;

  st_align u_align (
    .func3 (st_func3),
    .addr  (st_addr),
    .data  (st_data),
    .entry (in_entry),
    .legal (in_legal)
  );

  assign full     = (count_q == FullCnt);
  assign empty    = (count_q == '0);
  assign st_ready = ~full;
  assign accept   = st_valid & ~full;
  // Rejected requests are consumed by the handshake but never stored.
  assign push     = accept & in_legal;
  assign pop      = ~empty & mem_gnt;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      st_err_q <= accept & ~in_legal;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage is reset so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= in_entry;
    end
  end

  assign head      = buf_q[rd_ptr_q];
  assign mem_req   = ~empty;
  assign mem_addr  = {head.waddr, 2'b00};
  assign mem_wdata = head.wdata;
  assign mem_be    = head.be;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_st_align_buffer.sv
module tb_st_align_buffer;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_func3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_err;
  logic        empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  exp_t head_e;
  exp_t new_e;
  logic new_ok;
  logic err_exp;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  st_align_buffer #(.DEPTH(Depth)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_func3  (st_func3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .st_err    (st_err),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference encoding, written from the store-format rules.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       output exp_t e, output logic ok);
    logic [1:0] o;
    o = a[1:0];
    e.addr  = {a[31:2], 2'b00};
    e.wdata = d;
    e.be    = 4'b0000;
    ok      = 1'b0;
    if (f3 == 3'b000) begin
      ok = 1'b1;
      e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (o)
        2'd0: e.be = 4'b0001;
        2'd1: e.be = 4'b0010;
        2'd2: e.be = 4'b0100;
        default: e.be = 4'b1000;
      endcase
    end else if (f3 == 3'b001) begin
      ok = (o == 2'd0) || (o == 2'd2);
      e.wdata = {d[15:0], d[15:0]};
      e.be = (o == 2'd2) ? 4'b1100 : 4'b0011;
    end else if (f3 == 3'b010) begin
      ok = (o == 2'd0);
      e.be = 4'b1111;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      err_exp = 1'b0;
    end else begin
      check("st_err", {31'd0, st_err}, {31'd0, err_exp});
      check("empty_vs_model", {31'd0, empty}, {31'd0, sb_q.size() == 0});
      check("ready_vs_model", {31'd0, st_ready}, {31'd0, sb_q.size() < Depth});
      if (mem_req && sb_q.size() == 0) check("spurious_req", {31'd0, mem_req}, 32'd0);
      if (mem_req && mem_gnt && sb_q.size() > 0) begin
        head_e = sb_q.pop_front();
        check("mem_addr", mem_addr, head_e.addr);
        check("mem_wdata", mem_wdata, head_e.wdata);
        check("mem_be", {28'd0, mem_be}, {28'd0, head_e.be});
      end
      err_exp = 1'b0;
      if (st_valid && st_ready) begin
        model(st_func3, st_addr, st_data, new_e, new_ok);
        if (new_ok) sb_q.push_back(new_e);
        else err_exp = 1'b1;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and return just after the edge that accepts it.
  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_func3 = f3;
    st_addr  = a;
    st_data  = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (st_ready) break;
      if (n == 99) check("ready_timeout", 32'd0, 32'd1);
    end
    sync();
    st_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_func3 = 3'd0;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    mem_gnt  = 1'b0;
    #1;
    check("rst_ready", {31'd0, st_ready}, 32'd1);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_err", {31'd0, st_err}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    repeat (2) sync();
    rst_n = 1'b1;
    sync();

    // Byte and half encoding.
    mem_gnt = 1'b1;
    store(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    store(3'b001, 32'h0000_2002, 32'h1234_5678);
    repeat (3) sync();

    // Word store: visible the cycle after acceptance.
    store(3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_latency", {31'd0, mem_req}, 32'd1);
    repeat (3) sync();

    // Misaligned and illegal requests.
    store(3'b001, 32'h0000_0101, 32'h1111_1111);
    @(negedge clk);
    check("err_sh", {31'd0, st_err}, 32'd1);
    check("err_sh_empty", {31'd0, empty}, 32'd1);
    sync();
    store(3'b010, 32'h0000_0102, 32'h2222_2222);
    @(negedge clk);
    check("err_sw", {31'd0, st_err}, 32'd1);
    check("err_sw_req", {31'd0, mem_req}, 32'd0);
    sync();
    store(3'b011, 32'h0000_0100, 32'h3333_3333);
    @(negedge clk);
    check("err_f3", {31'd0, st_err}, 32'd1);
    check("err_f3_empty", {31'd0, empty}, 32'd1);
    sync();
    @(negedge clk);
    check("err_one_cycle", {31'd0, st_err}, 32'd0);
    sync();

    // Backpressure with the memory stalled.
    mem_gnt = 1'b0;
    store(3'b010, 32'h0000_0100, 32'h1111_1111);
    store(3'b010, 32'h0000_0104, 32'h2222_2222);
    st_valid = 1'b1;
    st_func3 = 3'b010;
    st_addr  = 32'h0000_0108;
    st_data  = 32'h3333_3333;
    repeat (3) begin
      @(negedge clk);
      check("held_off", {31'd0, st_ready}, 32'd0);
      check("hold_req", {31'd0, mem_req}, 32'd1);
      check("hold_addr", mem_addr, 32'h0000_0100);
      check("hold_wdata", mem_wdata, 32'h1111_1111);
      check("hold_be", {28'd0, mem_be}, 32'hF);
    end
    sync();
    mem_gnt = 1'b1;
    sync();
    mem_gnt = 1'b0;
    @(negedge clk);
    check("ready_back", {31'd0, st_ready}, 32'd1);
    sync();
    st_valid = 1'b0;
    mem_gnt  = 1'b1;
    repeat (4) sync();
    check("bp_drained", sb_q.size(), 32'd0);

    // Back-to-back stores with concurrent issue; pointers wrap several times.
    for (int i = 0; i < 10; i++) begin
      store(3'(i % 3), 32'h0000_3000 + 32'(i * 4) + 32'((i % 3 == 0) ? (i % 4) : 0),
            32'hC0DE_0000 + 32'(i * 32'h0101));
      if (i > 0) check("stream_not_empty", {31'd0, empty}, 32'd0);
    end
    repeat (4) sync();
    check("stream_drained", sb_q.size(), 32'd0);

    // Reset while full.
    mem_gnt = 1'b0;
    store(3'b010, 32'h0000_5000, 32'h5555_5555);
    store(3'b010, 32'h0000_5004, 32'h6666_6666);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_empty", {31'd0, empty}, 32'd1);
    check("rst_mid_ready", {31'd0, st_ready}, 32'd1);
    sync();
    rst_n   = 1'b1;
    mem_gnt = 1'b1;
    repeat (5) sync();
    @(negedge clk);
    check("no_issue_after_rst", {31'd0, mem_req}, 32'd0);
    sync();
    check("final_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
